buffer_lane_packer: RTL
=======================

// Module: buffer_lane_packer
// PURPOSE
//  Upstream feeder for the 4-lane Buffer. Accepts a serial stream of DATA_WIDTH words on a valid/ready port.
//  Packs four words into lanes 0..3 and issues them as one wide write (multi_width=1).
//  Drains partial groups one word at a time (multi_width=0) on flush or idle timeout.
//  All issues are back-pressured by the Buffer's full flag.
// PARAMETERS
//  DATA_WIDTH  40  width of each word / Buffer lane
//  TIMEOUT     16  idle cycles with a partial group before auto-drain (>=2)
//  CNT_WIDTH   16  width of the issue_cnt status counter
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           reset, asynchronous, active-low
//  s_valid      in   1           upstream word valid
//  s_data       in   DATA_WIDTH  upstream word
//  s_ready      out  1           packer can accept s_data this cycle
//  flush        in   1           level; drain any partial group
//  full         in   1           Buffer full; no issue while high
//  in_ready     out  1           write strobe to Buffer; Buffer takes the data at that clk edge
//  multi_width  out  1           1=all four lanes valid, 0=lane 0 only
//  in_data0..3  out  DATA_WIDTH  lane data to Buffer
//  issue_cnt    out  CNT_WIDTH   count of in_ready pulses, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (rst=0, async): state=COLLECT, count=0, idle=0, issue_cnt=0, lanes=0.
//   s_ready, in_ready and multi_width are 0 while rst is low.
//  State: lane[0..3] registers, count 0..4, idle counter, FSM {COLLECT, WIDE, DRAIN}.
//  s_ready  = (state==COLLECT) && (count<4). A word is accepted when s_valid && s_ready at the edge.
//  COLLECT:
//   - accept -> lane[count]<=s_data, count+1, idle<=0; count reaching 4 -> WIDE next cycle.
//   - no accept, count>0 -> idle increments, saturating at TIMEOUT.
//   - count>0 and (flush || idle==TIMEOUT-1), and this cycle's accept does not make count 4 -> DRAIN.
//   - accept + flush in the same cycle: the word is stored first, then drained with the group.
//   - If that accept makes count 4, go to WIDE instead.
//   - flush with count==0: ignored.
//  WIDE:
//   - in_ready = !full, multi_width=1, in_data0..3 = lane[0..3].
//   - Edge with in_ready=1 -> count<=0, idle<=0, COLLECT.
//   - full high: hold state and data unchanged, with no limit.
//  DRAIN:
//   - in_ready = !full, multi_width=0, in_data0 = lane[0], in_data1..3 driven 0.
//   - Edge with in_ready=1 -> shift lanes down by one and decrement count.
//   - count reaching 0 -> COLLECT with idle=0. One word per cycle while full is low.
//  Outside issue cycles: in_ready=0, multi_width=0, in_data0..3=0.
//  Latency: 4th accepted word -> in_ready possible on the next cycle. Wide throughput is 4 words per 5 cycles.
//  issue_cnt increments on every edge with in_ready=1, for both wide and single issues.
//  Reset mid-issue: all held lanes are discarded. No in_ready occurs after rst falls.
// TESTING
//  1. Send 0x01,0x02,0x03,0x04 back-to-back, full=0
//     -> one in_ready pulse, multi_width=1, in_data0..3=01,02,03,04; issue_cnt=1.
//  2. As 1, but full=1 for 3 cycles at WIDE
//     -> in_ready stays 0 and s_ready=0 throughout; data stable; a single pulse after full falls.
//  3. Send 0xA,0xB, then pulse flush
//     -> two single pulses with multi_width=0: in_data0=0xA then 0xB, in_data1..3=0; then COLLECT.
//  4. Send one word 0x55, then idle
//     -> single pulse with in_data0=0x55 exactly TIMEOUT cycles after the accept edge.
//  5. 3 words, then s_valid + flush together with 4th word 0x44
//     -> wide issue of all four, no single-width pulses.
//  6. Assert rst low while in WIDE with full=1
//     -> outputs 0 immediately; after release s_ready=1, issue_cnt=0, no stale issue.

Source files
------------

// File: rtl/buffer_lane_packer_if.sv
// Stream-in / Buffer-write bundle for buffer_lane_packer.
// master is the packer's view; slave is the upstream source plus Buffer side.
interface buffer_lane_packer_if #(
  parameter int DATA_WIDTH = 40
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  full;
  logic                  in_ready;
  logic                  multi_width;
  logic [DATA_WIDTH-1:0] in_data0;
  logic [DATA_WIDTH-1:0] in_data1;
  logic [DATA_WIDTH-1:0] in_data2;
  logic [DATA_WIDTH-1:0] in_data3;

  modport master (
    input  s_valid, s_data, full,
    output s_ready, in_ready, multi_width, in_data0, in_data1, in_data2, in_data3
  );

  modport slave (
    output s_valid, s_data, full,
    input  s_ready, in_ready, multi_width, in_data0, in_data1, in_data2, in_data3
  );
endinterface

// File: rtl/buffer_lane_packer.sv
// Packs a serial word stream into 4-lane wide writes for the Buffer; partial
// groups drain one word at a time on flush or after an idle timeout.
module buffer_lane_packer #(
  parameter int DATA_WIDTH = 40,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  buffer_lane_packer_if.master     bus,
  input  logic                     flush,
  output logic [CNT_WIDTH-1:0]     issue_cnt
);
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WIDE    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [2:0]            count_q, count_d;
  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [DATA_WIDTH-1:0] lane_q [4];
  logic [DATA_WIDTH-1:0] lane_d [4];
  logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;

  logic       accept;
  logic       issue;
  logic       issuing_state;
  logic [2:0] count_acc;

  // Outputs are gated by rst so nothing is offered or issued while reset is held.
  always_comb begin
    issuing_state   = (state_q == ST_WIDE) || (state_q == ST_DRAIN);
    bus.s_ready     = rst && (state_q == ST_COLLECT) && (count_q < 3'd4);
    accept          = bus.s_valid && bus.s_ready;
    issue           = rst && issuing_state && !bus.full;
    bus.in_ready    = issue;
    bus.multi_width = rst && (state_q == ST_WIDE);
    bus.in_data0    = (rst && issuing_state) ? lane_q[0] : '0;
    bus.in_data1    = bus.multi_width ? lane_q[1] : '0;
    bus.in_data2    = bus.multi_width ? lane_q[2] : '0;
    bus.in_data3    = bus.multi_width ? lane_q[3] : '0;
    issue_cnt       = issue_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idle_d      = idle_q;
    lane_d      = lane_q;
    count_acc   = count_q + {2'b00, accept};
    issue_cnt_d = issue_cnt_q + CNT_WIDTH'(issue);
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          lane_d[count_q[1:0]] = bus.s_data;
          idle_d               = '0;
        end else if (count_q != 3'd0 && idle_q != IDLE_MAX) begin
          idle_d = idle_q + 1'b1;
        end
        count_d = count_acc;
        // A completed group always wins over a flush or timeout drain.
        if (count_acc == 3'd4)
          state_d = ST_WIDE;
        else if (count_acc != 3'd0 && (flush || idle_q == IDLE_LAST))
          state_d = ST_DRAIN;
      end
      ST_WIDE: begin
        if (issue) begin
          count_d = '0;
          idle_d  = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        if (issue) begin
          lane_d[0] = lane_q[1];
          lane_d[1] = lane_q[2];
          lane_d[2] = lane_q[3];
          lane_d[3] = '0;
          count_d   = count_q - 3'd1;
          if (count_q == 3'd1) begin
            idle_d  = '0;
            state_d = ST_COLLECT;
          end
        end
      end
      default: begin
        count_d = '0;
        idle_d  = '0;
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_COLLECT;
      count_q     <= '0;
      idle_q      <= '0;
      issue_cnt_q <= '0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      issue_cnt_q <= issue_cnt_d;
      for (int i = 0; i < 4; i++) lane_q[i] <= lane_d[i];
    end
  end
endmodule
